// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - rv32 load/store unit bridging the memory stage to a data memory port
//
// Accepts one LB/LH/LW/LBU/LHU/SB/SH/SW access at a time. It checks funct3 and
// alignment, and issues a word-aligned, byte-strobed request to data memory. It then
// waits a variable number of cycles for mem_ack, or times out, and returns extended
// load data or an error code as a one-cycle response pulse.
//
// Ports:
//   clk, rst                       clock (rising edge), synchronous active-high reset
//   req_valid/req_ready            core access handshake (ready only in IDLE)
//   req_we, req_funct3             access kind: store flag and RV32I funct3
//   req_addr, req_wdata            byte address, right-aligned store data
//   resp_valid                     one-cycle completion pulse
//   resp_rdata, resp_err           extended load data, error (00 ok, 01 misaligned,
//                                  10 illegal funct3, 11 bus timeout)
//   mem_req, mem_we                data memory request (held until ack) and write enable
//   mem_addr, mem_wdata, mem_wstrb word address, lane-replicated data, byte strobes
//   mem_ack, mem_rdata             memory completion and read word
module load_store_unit #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_F3    = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;
    localparam logic [7:0] TMO_LAST  = 8'(MEM_TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;

    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic [1:0]  resp_err_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wstrb_q;

    // Decode of the presented request and of the returning read word.
    logic        illegal_d;
    logic        misaligned_d;
    logic [31:0] wdata_d;
    logic [3:0]  wstrb_d;
    logic [7:0]  byte_d;
    logic [15:0] half_d;
    logic [31:0] load_d;

    always_comb begin
        illegal_d    = 1'b0;
        misaligned_d = 1'b0;
        wdata_d      = 32'h0;
        wstrb_d      = 4'b0000;
        if (req_we) begin
            illegal_d = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            illegal_d = (req_funct3 inside {3'b011, 3'b110, 3'b111});
        end
        // funct3[1:0] selects the width for both signed and unsigned variants
        misaligned_d = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    wdata_d = {4{req_wdata[7:0]}};
                    wstrb_d = 4'b0001 << req_addr[1:0];
                end
                2'b01: begin
                    wdata_d = {2{req_wdata[15:0]}};
                    wstrb_d = req_addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    wdata_d = req_wdata;
                    wstrb_d = 4'b1111;
                end
            endcase
        end

        case (lo_q)
            2'b00:   byte_d = mem_rdata[7:0];
            2'b01:   byte_d = mem_rdata[15:8];
            2'b10:   byte_d = mem_rdata[23:16];
            default: byte_d = mem_rdata[31:24];
        endcase
        half_d = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_d = {{24{byte_d[7]}}, byte_d};
            3'b100:  load_d = {24'h0, byte_d};
            3'b001:  load_d = {{16{half_d[15]}}, half_d};
            3'b101:  load_d = {16'h0, half_d};
            default: load_d = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 8'h0;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            lo_q         <= 2'b00;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= ERR_OK;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_wstrb_q  <= 4'b0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q <= req_we;
                        f3_q <= req_funct3;
                        lo_q <= req_addr[1:0];
                        if (illegal_d) begin
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= 32'h0;
                            resp_err_q   <= ERR_F3;
                            state_q      <= RESP;
                        end else if (misaligned_d) begin
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= 32'h0;
                            resp_err_q   <= ERR_ALIGN;
                            state_q      <= RESP;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_we;
                            mem_addr_q  <= {req_addr[31:2], 2'b00};
                            mem_wdata_q <= wdata_d;
                            mem_wstrb_q <= wstrb_d;
                            cnt_q       <= 8'h0;
                            state_q     <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (mem_ack || (cnt_q == TMO_LAST)) begin
                        mem_req_q    <= 1'b0;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= 32'h0;
                        mem_wdata_q  <= 32'h0;
                        mem_wstrb_q  <= 4'b0000;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                        if (mem_ack) begin
                            resp_rdata_q <= we_q ? 32'h0 : load_d;
                            resp_err_q   <= ERR_OK;
                        end else begin
                            resp_rdata_q <= 32'h0;
                            resp_err_q   <= ERR_TMO;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'h1;
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= 32'h0;
                    resp_err_q   <= ERR_OK;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Ready is the only state decode; it is forced low while reset is asserted.
    assign req_ready  = (state_q == IDLE) && !rst;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    load_store_unit #(.MEM_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access: drive it at a negedge, play the memory (ack on the ack_lat-th
    // mem_req cycle, 0 = never), and compare the response against the scoreboard.
    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int ack_lat,
                          input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                          input logic [31:0] exp_maddr, input logic [31:0] exp_mwdata,
                          input logic [3:0] exp_wstrb, input int exp_nreq, input int exp_lat);
        exp_t e;
        exp_t got;
        int   cyc;
        int   nreq;
        bit   seen;
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        e.rdata    = exp_rdata;
        e.err      = exp_err;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        cyc  = 1;
        nreq = 0;
        seen = 1'b0;
        while (cyc < 300) begin
            mem_ack = 1'b0;
            if (resp_valid === 1'b1) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    chk({tag, ".sb_empty"}, 32'(sb.size()), 32'd1);
                end else begin
                    got = sb.pop_front();
                    chk({tag, ".rdata"}, resp_rdata, got.rdata);
                    chk({tag, ".err"}, 32'(resp_err), 32'(got.err));
                end
                break;
            end
            if (mem_req === 1'b1) begin
                nreq++;
                chk({tag, ".maddr"}, mem_addr, exp_maddr);
                chk({tag, ".mwe"}, 32'(mem_we), 32'(we));
                chk({tag, ".wstrb"}, 32'(mem_wstrb), 32'(exp_wstrb));
                if (we) chk({tag, ".mwdata"}, mem_wdata, exp_mwdata);
                if (nreq == ack_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
            end
            @(negedge clk);
            cyc++;
        end
        mem_ack = 1'b0;
        chk({tag, ".resp_seen"}, 32'(seen), 32'd1);
        chk({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, ".nreq"}, 32'(nreq), 32'(exp_nreq));
        @(negedge clk);
        chk({tag, ".pulse_end"}, 32'(resp_valid), 32'd0);
        chk({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        repeat (3) @(negedge clk);

        chk("reset.ready", 32'(req_ready), 32'd0);
        chk("reset.resp_valid", 32'(resp_valid), 32'd0);
        chk("reset.resp_rdata", resp_rdata, 32'd0);
        chk("reset.resp_err", 32'(resp_err), 32'd0);
        chk("reset.mem_req", 32'(mem_req), 32'd0);
        chk("reset.mem_we", 32'(mem_we), 32'd0);
        chk("reset.mem_addr", mem_addr, 32'd0);
        chk("reset.mem_wdata", mem_wdata, 32'd0);
        chk("reset.mem_wstrb", 32'(mem_wstrb), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset.ready", 32'(req_ready), 32'd1);

        //     tag     we  f3      addr          wdata         rdata         lat exp_rdata     err    maddr         mwdata        wstrb    nreq lat
        access("lb",   0, 3'b000, 32'h0000_0100, 32'h0,        32'h0000_06F4, 1, 32'hFFFF_FFF4, 2'b00, 32'h0000_0100, 32'h0,        4'b0000, 1, 2);
        access("lbu",  0, 3'b100, 32'h0000_0100, 32'h0,        32'h0000_06F4, 1, 32'h0000_00F4, 2'b00, 32'h0000_0100, 32'h0,        4'b0000, 1, 2);
        access("lb1",  0, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_06F4, 1, 32'h0000_0006, 2'b00, 32'h0000_0100, 32'h0,        4'b0000, 1, 2);
        access("lh",   0, 3'b001, 32'h0000_0100, 32'h0,        32'h0000_06F4, 1, 32'h0000_06F4, 2'b00, 32'h0000_0100, 32'h0,        4'b0000, 1, 2);
        access("lhu2", 0, 3'b101, 32'h0000_0102, 32'h0,        32'h0000_06F4, 1, 32'h0000_0000, 2'b00, 32'h0000_0100, 32'h0,        4'b0000, 1, 2);
        access("lh2s", 0, 3'b001, 32'h0000_0102, 32'h0,        32'h8000_1234, 1, 32'hFFFF_8000, 2'b00, 32'h0000_0100, 32'h0,        4'b0000, 1, 2);
        access("lb3",  0, 3'b000, 32'h0000_0103, 32'h0,        32'h7F00_0000, 2, 32'h0000_007F, 2'b00, 32'h0000_0100, 32'h0,        4'b0000, 2, 3);
        access("lw",   0, 3'b010, 32'h0000_0200, 32'h0,        32'h89AB_CDEF, 2, 32'h89AB_CDEF, 2'b00, 32'h0000_0200, 32'h0,        4'b0000, 2, 3);
        access("sb3",  1, 3'b000, 32'h0000_0103, 32'h1234_56AB, 32'hFFFF_FFFF, 1, 32'h0,        2'b00, 32'h0000_0100, 32'hABAB_ABAB, 4'b1000, 1, 2);
        access("sb1",  1, 3'b000, 32'h0000_0101, 32'h0000_0055, 32'h0,        1, 32'h0,        2'b00, 32'h0000_0100, 32'h5555_5555, 4'b0010, 1, 2);
        access("sh2",  1, 3'b001, 32'h0000_0102, 32'hDEAD_1234, 32'hFFFF_FFFF, 1, 32'h0,        2'b00, 32'h0000_0100, 32'h1234_1234, 4'b1100, 1, 2);
        access("sh0",  1, 3'b001, 32'h0000_0100, 32'h0000_BEEF, 32'h0,        1, 32'h0,        2'b00, 32'h0000_0100, 32'hBEEF_BEEF, 4'b0011, 1, 2);
        access("sw",   1, 3'b010, 32'h0000_0104, 32'hCAFE_BABE, 32'h0,        3, 32'h0,        2'b00, 32'h0000_0104, 32'hCAFE_BABE, 4'b1111, 3, 4);
        access("lwmis",0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        1, 32'h0,        2'b01, 32'h0,        32'h0,        4'b0000, 0, 1);
        access("lhmis",0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        1, 32'h0,        2'b01, 32'h0,        32'h0,        4'b0000, 0, 1);
        access("swmis",1, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        1, 32'h0,        2'b01, 32'h0,        32'h0,        4'b0000, 0, 1);
        access("ldf3", 0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        1, 32'h0,        2'b10, 32'h0,        32'h0,        4'b0000, 0, 1);
        access("f3pri",0, 3'b110, 32'h0000_0103, 32'h0,        32'h0,        1, 32'h0,        2'b10, 32'h0,        32'h0,        4'b0000, 0, 1);
        access("stf3", 1, 3'b100, 32'h0000_0100, 32'h0,        32'h0,        1, 32'h0,        2'b10, 32'h0,        32'h0,        4'b0000, 0, 1);
        access("tmo",  0, 3'b010, 32'h0000_0200, 32'h0,        32'h0,        0, 32'h0,        2'b11, 32'h0000_0200, 32'h0,        4'b0000, 4, 5);
        access("aftmo",0, 3'b010, 32'h0000_0204, 32'h0,        32'h1357_9BDF, 1, 32'h1357_9BDF, 2'b00, 32'h0000_0204, 32'h0,        4'b0000, 1, 2);

        // Reset while a request is outstanding, then a late ack.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0300;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstbus.mem_req_up", 32'(mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstbus.mem_req", 32'(mem_req), 32'd0);
        chk("rstbus.resp_valid", 32'(resp_valid), 32'd0);
        chk("rstbus.ready_in_rst", 32'(req_ready), 32'd0);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rstbus.ready", 32'(req_ready), 32'd1);
        chk("rstbus.mem_req_after", 32'(mem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("rstbus.no_resp", 32'(resp_valid), 32'd0);
            @(negedge clk);
        end

        access("final",0, 3'b100, 32'h0000_0102, 32'h0,        32'h00C3_0000, 1, 32'h0000_00C3, 2'b00, 32'h0000_0100, 32'h0,        4'b0000, 1, 2);
        chk("sb.drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Bridges the rv32 core's memory stage to the data memory port for LB/LH/LW/LBU/LHU/SB/SH/SW. It accepts one access at a time from the core and checks alignment and funct3. It issues a word-aligned request with byte strobes to data memory and waits for an ack of variable latency. It then returns sign- or zero-extended load data to the core's writeback path, or an error code.

## Interface
- MEM_TIMEOUT, 64: cycles with mem_req held and no mem_ack before a bus-timeout error; legal range 1..255.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents an access.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I load/store funct3.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 bus timeout.
- mem_req  out  1  request to data memory, held until mem_ack.
- mem_we  out  1  write enable.
- mem_addr  out  32  {addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte strobes; 0000 for loads.
- mem_ack  in  1  memory accepted the write or returns mem_rdata this cycle.
- mem_rdata  in  32  read word, valid with mem_ack.

## Operation
- States: IDLE, BUS, RESP.
- IDLE: req_ready=1. When req_valid is high, latch we/funct3/addr/wdata.
  - Illegal funct3 goes to RESP with err=10. Illegal values: loads 011/110/111; stores anything other than 000/001/010.
  - Misalignment goes to RESP with err=01. Cases: half (x01) with addr[0]=1; word (010) with addr[1:0]≠0. The funct3 check has priority over misalignment.
  - Otherwise go to BUS.
  - No memory access is made on any error.
- BUS: mem_req=1 with stable mem_we/addr/wdata/wstrb.
  - On mem_ack: capture the extracted data and go to RESP with err=00.
  - If the wait counter reaches MEM_TIMEOUT without an ack: drop mem_req and go to RESP with err=11.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Store lanes:
  - SB: wdata[7:0] replicated ×4; wstrb = 0001 << addr[1:0].
  - SH: wdata[15:0] replicated ×2; wstrb = 0011 (addr[1]=0) or 1100 (addr[1]=1).
  - SW: wdata; wstrb = 1111.
- Load extract:
  - Byte: b = mem_rdata[8*addr[1:0] +: 8]. LB sign-extends b[7]; LBU zero-extends.
  - Half: h = mem_rdata[16*addr[1] +: 16]. LH sign-extends; LHU zero-extends.
  - LW: mem_rdata unchanged.
- req_valid while not IDLE is ignored, and the request is not latched.

## Timing
- Reset: state=IDLE, and every output is 0, including req_ready while rst is high. req_ready=1 from the first cycle after rst deasserts.
- Accept edge is T0. mem_req rises at T0+1 (registered). With mem_ack at cycle Tk (k≥1), resp_valid is high at Tk+1. Minimum load/store latency is 2 cycles; next accept is possible at Tk+2.
- Error detected at accept: resp_valid at T0+1, mem_req never asserted.
- Timeout: the counter clears on entry to BUS and increments each BUS cycle without ack. At count = MEM_TIMEOUT−1 with no ack, mem_req falls the next edge and resp_valid pulses at that same edge's cycle.
- mem_ack outside BUS is ignored.
- rst mid-BUS: mem_req=0 and IDLE on the next edge; no resp_valid is generated. Data memory must tolerate an abandoned request.
- All outputs are registered; there is no combinational path from req_* or mem_* to outputs except req_ready, which is decoded from state.

## Test plan
- LB, addr 0x100, mem_rdata 0x000006F4, ack 1 cycle after mem_req -> mem_addr 0x100, wstrb 0000, resp_rdata 0xFFFFFFF4, err 00, resp_valid 2 cycles after accept.
- Same word: LBU @0x100 -> 0x000000F4; LB @0x101 -> 0x00000006; LH @0x100 -> 0x000006F4; LHU @0x102 -> 0x00000000.
- SB 0xAB @0x103 -> mem_we 1, wdata 0xABABABAB, wstrb 1000. SH 0x1234 @0x102 -> wdata 0x12341234, wstrb 1100. resp_rdata 0.
- LW @0x102 -> err 01, resp_valid at T0+1, mem_req stays 0. Load funct3 011 -> err 10.
- MEM_TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, then resp err 11. Next access is accepted normally.
- rst pulsed while mem_req is high -> mem_req 0 and req_ready 1 after reset. A late mem_ack is ignored and there is no resp_valid.
